// File: rtl/puf_id_tx.sv
// puf_id_tx: serialises the error-corrected PUF ID as one UART-style frame
// (start bit, LSB-first data, optional even parity, stop bit).
//
// Handshake: I_data_v is a one-cycle strobe with no ready back-pressure.
// A strobe seen in IDLE is accepted on that edge and I_data is captured.
// This includes the single O_done cycle, so back-to-back frames carry no
// idle bit-time. A strobe seen while O_busy is high is dropped, the frame
// in flight is left untouched, and the sticky O_ovf flag is raised on the
// next edge.
module puf_id_tx #(
  parameter int DATA_BITS = 24,
  parameter int DIV_WIDTH = 8,
  parameter int BIT_DIV   = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [DATA_BITS-1:0] I_data,
  input  logic                 I_data_v,
  input  logic                 I_ovf_clr,
  output logic                 O_tx,
  output logic                 O_busy,
  output logic                 O_done,
  output logic                 O_ovf
);

  // Bit counter wide enough to hold DATA_BITS without wrapping.
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(BIT_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 parity_acc;
  logic                 done;
  logic                 ovf;

  logic bit_end;
  logic last_bit;
  logic accept;
  logic drop;

  // Per-cycle events: end of a bit period, final data bit, accept and drop.
  always_comb begin
    bit_end  = (div_cnt == DIV_LAST);
    last_bit = (bit_cnt == LAST_BIT);
    accept   = (state == S_IDLE) && I_data_v;
    drop     = (state != S_IDLE) && I_data_v;
  end

  // Next-state decode; every state except IDLE advances only at a bit end.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (I_data_v) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && last_bit) state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register; an asynchronous reset aborts any frame in flight.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: capture on accept, then divider, shifter and parity per bit.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      parity_acc <= 1'b0;
    end else if (accept) begin
      shift_reg  <= I_data;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      parity_acc <= 1'b0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (state == S_DATA) begin
          shift_reg  <= shift_reg >> 1;
          parity_acc <= parity_acc ^ shift_reg[0];
          bit_cnt    <= bit_cnt + CNT_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_WIDTH'(1);
      end
    end
  end

  // Done pulse for the first IDLE cycle after the stop bit completes.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == S_STOP) && bit_end;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (I_ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Line driver, decoded straight from state so reset forces idle-high at once.
  always_comb begin
    O_tx = 1'b1;
    case (state)
      S_IDLE:   O_tx = 1'b1;
      S_START:  O_tx = 1'b0;
      S_DATA:   O_tx = shift_reg[0];
      S_PARITY: O_tx = parity_acc;
      S_STOP:   O_tx = 1'b1;
      default:  O_tx = 1'b1;
    endcase
  end

  // Status outputs.
  always_comb begin
    O_busy = (state != S_IDLE);
    O_done = done;
    O_ovf  = ovf;
  end

endmodule

// File: tb/tb_puf_id_tx.sv
// tb_puf_id_tx: directed bench for puf_id_tx. dut_a uses the defaults
// (24 bits, BIT_DIV=4, parity on); dut_b uses BIT_DIV=1 with parity off.
module tb_puf_id_tx;

  logic        clk;
  logic        rst;
  logic [23:0] data_a;
  logic        dv_a;
  logic        clr_a;
  logic        tx_a, busy_a, done_a, ovf_a;
  logic [23:0] data_b;
  logic        dv_b;
  logic        clr_b;
  logic        tx_b, busy_b, done_b, ovf_b;

  int checks;
  int errors;

  puf_id_tx #(.DATA_BITS(24), .DIV_WIDTH(8), .BIT_DIV(4), .PARITY_EN(1)) dut_a (
    .I_clk(clk), .I_rst(rst), .I_data(data_a), .I_data_v(dv_a), .I_ovf_clr(clr_a),
    .O_tx(tx_a), .O_busy(busy_a), .O_done(done_a), .O_ovf(ovf_a)
  );

  puf_id_tx #(.DATA_BITS(24), .DIV_WIDTH(8), .BIT_DIV(1), .PARITY_EN(0)) dut_b (
    .I_clk(clk), .I_rst(rst), .I_data(data_b), .I_data_v(dv_b), .I_ovf_clr(clr_b),
    .O_tx(tx_b), .O_busy(busy_b), .O_done(done_b), .O_ovf(ovf_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference line value for frame cycle k (1 = first start-bit cycle).
  function automatic logic exp_tx(input logic [23:0] d, input int k, input int div, input int par_en);
    int slot;
    slot = (k - 1) / div;
    if (slot == 0) return 1'b0;
    if (slot <= 24) return d[slot-1];
    if (slot == 25 && par_en != 0) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: tx=%b busy=%b done=%b ovf=%b, want 1 0 0 0", tx_a, busy_a, done_a, ovf_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: tx=%b busy=%b done=%b ovf=%b, want 1 0 0 0", tx_b, busy_b, done_b, ovf_b);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b busy=%b, want 1 0", tx_a, busy_a);
    end
  endtask

  // Frame A5C3F0 against a hand-written bit sequence (send order).
  task automatic test_frame_a5c3f0();
    logic [0:23] hand;
    logic        want;
    int          slot;
    hand   = 24'b0000_1111_1100_0011_1010_0101;
    data_a = 24'hA5C3F0;
    dv_a   = 1'b1;
    tick();
    dv_a   = 1'b0;
    data_a = 24'h5A3C0F;  // changes outside acceptance must be ignored
    for (int k = 1; k <= 108; k++) begin
      slot = (k - 1) / 4;
      if (slot == 0) want = 1'b0;
      else if (slot <= 24) want = hand[slot-1];
      else if (slot == 25) want = 1'b0;
      else want = 1'b1;
      checks++;
      if (tx_a !== want || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL a5c3f0_cycle%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0", k, tx_a, busy_a, done_a, want);
      end
      tick();
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL a5c3f0_done109: done=%b busy=%b tx=%b, want 1 0 1", done_a, busy_a, tx_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL a5c3f0_done_width: done=%b, want 0", done_a);
    end
  endtask

  // Single set bit: parity slot must be 1.
  task automatic test_single_bit();
    logic [23:0] d;
    d      = 24'h000001;
    data_a = d;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int k = 1; k <= 108; k++) begin
      checks++;
      if (tx_a !== exp_tx(d, k, 4, 1) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL single_bit_cycle%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_a, busy_a, exp_tx(d, k, 4, 1));
      end
      if (k == 101) begin
        checks++;
        if (tx_a !== 1'b1) begin
          errors++;
          $display("FAIL single_bit_parity: tx=%b, want 1", tx_a);
        end
      end
      tick();
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL single_bit_done: done=%b, want 1", done_a);
    end
    tick();
  endtask

  // Dropped strobe mid-frame, clear, and set-beats-clear.
  task automatic test_overflow();
    logic [23:0] d;
    d      = 24'h00F00F;
    data_a = d;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int k = 1; k <= 108; k++) begin
      checks++;
      if (tx_a !== exp_tx(d, k, 4, 1) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL ovf_frame_cycle%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_a, busy_a, exp_tx(d, k, 4, 1));
      end
      if (k == 50) begin
        checks++;
        if (ovf_a !== 1'b0) begin
          errors++;
          $display("FAIL ovf_before_drop: ovf=%b, want 0", ovf_a);
        end
      end
      if (k == 51) begin
        checks++;
        if (ovf_a !== 1'b1) begin
          errors++;
          $display("FAIL ovf_after_drop: ovf=%b, want 1", ovf_a);
        end
      end
      dv_a   = (k == 50);
      data_a = (k == 50) ? 24'hFFFFFF : d;
      tick();
    end
    checks++;
    if (done_a !== 1'b1 || ovf_a !== 1'b1) begin
      errors++;
      $display("FAIL ovf_frame_done: done=%b ovf=%b, want 1 1", done_a, ovf_a);
    end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b, want 0", ovf_a);
    end
    // New frame; drop at cycle 1, drop+clear at cycle 2, clear alone at cycle 3.
    data_a = 24'h123456;
    dv_a   = 1'b1;
    tick();
    tick();
    checks++;
    if (ovf_a !== 1'b1) begin
      errors++;
      $display("FAIL ovf_second_drop: ovf=%b, want 1", ovf_a);
    end
    clr_a = 1'b1;
    tick();
    dv_a = 1'b0;
    checks++;
    if (ovf_a !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b, want 1", ovf_a);
    end
    tick();
    clr_a = 1'b0;
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_after: ovf=%b, want 0", ovf_a);
    end
    for (int k = 4; k <= 108; k++) tick();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ovf_last_frame_done: done=%b busy=%b, want 1 0", done_a, busy_a);
    end
    tick();
  endtask

  // Second strobe lands in the O_done cycle: accepted, no gap, no overflow.
  task automatic test_back_to_back();
    logic [23:0] d1;
    logic [23:0] d2;
    d1     = 24'h3C3C3C;
    d2     = 24'hFFFFFF;
    data_a = d1;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int k = 1; k <= 108; k++) tick();
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b, want 1", done_a);
    end
    data_a = d2;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int k = 1; k <= 108; k++) begin
      checks++;
      if (tx_a !== exp_tx(d2, k, 4, 1) || busy_a !== 1'b1 || ovf_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b_cycle%0d: tx=%b busy=%b ovf=%b, want tx=%b busy=1 ovf=0", k, tx_a, busy_a, ovf_a, exp_tx(d2, k, 4, 1));
      end
      if (k == 101) begin
        checks++;
        if (tx_a !== 1'b0) begin
          errors++;
          $display("FAIL b2b_parity: tx=%b, want 0", tx_a);
        end
      end
      tick();
    end
    checks++;
    if (done_a !== 1'b1 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b ovf=%b, want 1 0", done_a, ovf_a);
    end
    tick();
  endtask

  // Asynchronous reset in mid-DATA, then a clean frame.
  task automatic test_reset_mid_frame();
    logic [23:0] d;
    data_a = 24'hA5C3F0;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int k = 1; k < 30; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b, want 1 0", tx_a, busy_a);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 90; k++) begin
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
        errors++;
        $display("FAIL no_done_after_reset%0d: done=%b busy=%b tx=%b, want 0 0 1", k, done_a, busy_a, tx_a);
      end
      tick();
    end
    d      = 24'h0F0F0F;
    data_a = d;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int k = 1; k <= 108; k++) begin
      checks++;
      if (tx_a !== exp_tx(d, k, 4, 1) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_cycle%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_a, busy_a, exp_tx(d, k, 4, 1));
      end
      tick();
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_done: done=%b, want 1", done_a);
    end
    tick();
  endtask

  // No parity, one cycle per bit: 26-cycle frame, done on cycle 27.
  task automatic test_fast_no_parity();
    logic [23:0] d;
    logic [0:25] hand;
    d      = 24'h800000;
    hand   = 26'b0_00000000000000000000000_1_1;
    data_b = d;
    dv_b   = 1'b1;
    tick();
    dv_b = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      checks++;
      if (tx_b !== hand[k-1] || busy_b !== 1'b1 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL fast_cycle%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0", k, tx_b, busy_b, done_b, hand[k-1]);
      end
      tick();
    end
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || tx_b !== 1'b1) begin
      errors++;
      $display("FAIL fast_done27: done=%b busy=%b tx=%b, want 1 0 1", done_b, busy_b, tx_b);
    end
    tick();
    checks++;
    if (done_b !== 1'b0) begin
      errors++;
      $display("FAIL fast_done_width: done=%b, want 0", done_b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    data_a = '0;
    dv_a   = 1'b0;
    clr_a  = 1'b0;
    data_b = '0;
    dv_b   = 1'b0;
    clr_b  = 1'b0;
    rst    = 1'b1;
    test_reset();
    test_frame_a5c3f0();
    test_single_bit();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_fast_no_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_id_tx.md
Name: puf_id_tx

Overview:
- Output stage downstream of the BCH decoder wrapper.
- When the controller signals that the decoder has finished, this block captures the error-corrected PUF ID (DATA_BITS wide).
- It sends the ID off-chip as one framed, UART-style serial word: start bit, LSB-first data, optional even parity, stop bit.
- It reports busy, frame done, and a sticky overflow flag for IDs that arrive while a frame is still being sent.

Parameters:
- DATA_BITS, 24, width of the corrected ID; must be 1..64.
- DIV_WIDTH, 8, width of the bit-period counter.
- BIT_DIV, 4, number of I_clk cycles per serial bit; range 1..2^DIV_WIDTH-1.
- PARITY_EN, 1, 1 = insert even parity bit after data; 0 = no parity bit.

Ports:
- I_clk  input  1  system clock; all logic on the rising edge.
- I_rst  input  1  asynchronous, active-high reset.
- I_data  input  DATA_BITS  corrected ID from the decoder; sampled only on the cycle it is accepted.
- I_data_v  input  1  one-cycle strobe: I_data is valid (decoder ready).
- I_ovf_clr  input  1  synchronous clear of O_ovf.
- O_tx  output  1  serial line; idles high.
- O_busy  output  1  high while a frame is in flight.
- O_done  output  1  one-cycle pulse after the stop bit completes.
- O_ovf  output  1  sticky: an I_data_v was dropped.

Behaviour:
- Reset (async assert, I_rst high):
  - Outputs: O_tx=1, O_busy=0, O_done=0, O_ovf=0.
  - Internal: state=IDLE, shift register=0, bit counter=0, divider=0, parity accumulator=0.
- Reset deassertion: sampled synchronously by the logic. Reset mid-frame aborts the frame immediately: O_tx returns to 1 and no O_done is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - O_tx=1, O_busy=0.
  - If I_data_v=1 at an edge: latch I_data into the shift register, clear the divider and bit counter, clear the parity accumulator, go to START.
- START:
  - O_tx=0 for BIT_DIV cycles.
  - The first start-bit cycle is the cycle after acceptance (1-cycle latency strobe to line).
- DATA:
  - O_tx = shift register bit 0, LSB first.
  - Each bit is held BIT_DIV cycles. At the end of each bit period: shift right, XOR the sent bit into the parity accumulator, increment the bit counter.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: O_tx = XOR of all data bits (even parity), held for BIT_DIV cycles.
- STOP: O_tx=1 for BIT_DIV cycles, then go to IDLE.
- O_done:
  - Pulses high for exactly the first IDLE cycle after STOP.
  - In that same cycle I_data_v is accepted, so back-to-back frames have zero idle bit-time. The next start bit follows on the cycle after.
- O_busy: 1 in START, DATA, PARITY and STOP.
- Frame length: (DATA_BITS + 2 + PARITY_EN) × BIT_DIV cycles. With the defaults this is 108 cycles.
- Divider:
  - Counts 0..BIT_DIV-1, advances the bit at BIT_DIV-1, then wraps to 0.
  - BIT_DIV=1 gives one cycle per bit with no stall.
- Bit counter: ceil(log2(DATA_BITS+1)) bits wide; no wrap within a frame.
- Overflow:
  - I_data_v=1 while O_busy=1: the data is dropped, the current frame is unaffected, and O_ovf is set on the next edge.
  - O_ovf stays set until I_ovf_clr or reset.
  - If I_ovf_clr=1 and a new drop happen in the same cycle, set wins (O_ovf stays 1).
- I_data changes outside the acceptance cycle have no effect.

Test Plan:
1. Reset, then I_data=24'hA5C3F0 with a one-cycle I_data_v (BIT_DIV=4, PARITY_EN=1) -> on the line:
   - start 0 for cycles 1-4;
   - data bits LSB first 0,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 4 cycles;
   - parity 0;
   - stop 1;
   - O_busy high for 108 cycles; O_done pulses on cycle 109.
2. I_data=24'h000001 -> data LSB 1 then 23 zeros; parity bit 1; O_done after 108 cycles.
3. I_data_v pulsed again at cycle 50 of a frame -> the frame completes unchanged, O_ovf=1 from cycle 51. Then I_ovf_clr -> O_ovf=0 next cycle. Then I_ovf_clr asserted in the same cycle as a new drop -> O_ovf stays 1.
4. I_data_v asserted in the O_done cycle with 24'hFFFFFF -> the second start bit begins the next cycle; parity 0; no O_ovf.
5. I_rst pulsed mid-DATA -> O_tx=1, O_busy=0 asynchronously; no O_done. A subsequent I_data_v sends a full, correct frame.
6. PARITY_EN=0, BIT_DIV=1, I_data=24'h800000 -> frame of 26 cycles: 0, then 23 zeros, then 1, then stop 1; O_done on cycle 27.
